// File: rtl/clock_divider_programmable.sv
// Runtime-programmable integer clock divider with a registered divided clock and tick strobe.
// New divisors are handed over through a load handshake and take effect only at a period boundary.
module clock_divider_programmable #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_err,
    output logic [DIV_W-1:0] div_active,
    output logic             clk_out,
    output logic             tick
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic [DIV_W-1:0] pending_q, pending_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             load_ok;
    logic             wrap;
    logic [DIV_W:0]   half;

    // Register bank; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            div_active_q <= DIV_W'(DEFAULT_DIV);
            pending_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    // Next-state, handshake and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        pending_d    = pending_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        load_ok      = div_load && !busy_q && (div_in >= DIV_W'(2));
        err_d        = div_load && !busy_q && (div_in < DIV_W'(2));
        wrap         = (cnt_q == (div_active_q - DIV_W'(1)));

        // A divisor loaded while idle was applied immediately; busy drops after one cycle.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (load_ok) begin
                    div_active_d = div_in;
                    busy_d       = 1'b1;
                    done_d       = 1'b1;
                end
                if (enable) begin
                    state_d = RUN;
                    if (busy_q && !done_q) begin
                        div_active_d = pending_q;
                        busy_d       = 1'b0;
                    end
                end
            end
            RUN: begin
                if (load_ok) begin
                    pending_d = div_in;
                    busy_d    = 1'b1;
                end
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
                    if (load_ok) begin
                        state_d = SWITCH;
                    end
                end
            end
            SWITCH: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    state_d      = RUN;
                    cnt_d        = '0;
                    div_active_d = pending_q;
                    busy_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // ceil(N/2) in one extra bit so N = 2^DIV_W-1 cannot overflow.
        half      = ({1'b0, div_active_d} + (DIV_W+1)'(1)) >> 1;
        clk_out_d = (state_d != IDLE) && ({1'b0, cnt_d} < half);
        tick_d    = (state_d != IDLE) && (cnt_d == '0);
    end

    assign div_busy   = busy_q;
    assign div_err    = err_q;
    assign div_active = div_active_q;
    assign clk_out    = clk_out_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_clock_divider_programmable.sv
// Directed bench for clock_divider_programmable: period patterns, load handshake, park and reset.
module tb_clock_divider_programmable;

    localparam int unsigned DIV_W = 8;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic [DIV_W-1:0] div_in;
    logic             div_load;
    logic             div_busy;
    logic             div_err;
    logic [DIV_W-1:0] div_active;
    logic             clk_out;
    logic             tick;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    clock_divider_programmable #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .div_in    (div_in),
        .div_load  (div_load),
        .div_busy  (div_busy),
        .div_err   (div_err),
        .div_active(div_active),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Checks clk_out/tick for a point in a period of length n at counter value c.
    task automatic chk_wave(input string tag, input int unsigned n, input int unsigned c);
        chk({tag, "_clk"}, 32'(clk_out), ((c < (n + 1) / 2) ? 1 : 0));
        chk({tag, "_tick"}, 32'(tick), ((c == 0) ? 1 : 0));
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        cyc();
        cyc();
        chk("rst_clk", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_active", 32'(div_active), 4);
        chk("rst_busy", 32'(div_busy), 0);
        chk("rst_err", 32'(div_err), 0);

        reset_n = 1'b1;
        cyc();
        chk("idle_clk", 32'(clk_out), 0);

        // Default divisor 4: 1100 with tick on the first cycle after enable.
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk_wave("n4", 4, i % 4);
        end

        // Load 5 mid-period; the 4-cycle period finishes first.
        cyc();
        chk_wave("n4_c0", 4, 0);
        div_load = 1'b1;
        div_in   = 8'd5;
        cyc();
        div_load = 1'b0;
        chk("ld5_busy", 32'(div_busy), 1);
        chk_wave("ld5_c1", 4, 1);
        cyc();
        chk_wave("ld5_c2", 4, 2);
        cyc();
        chk_wave("ld5_c3", 4, 3);
        chk("ld5_busy_c3", 32'(div_busy), 1);
        chk("ld5_old_active", 32'(div_active), 4);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_wave("n5", 5, i % 5);
            chk("n5_busy", 32'(div_busy), 0);
            chk("n5_active", 32'(div_active), 5);
        end

        // Invalid divisors 1 and 0 are rejected without disturbing the output.
        div_load = 1'b1;
        div_in   = 8'd1;
        cyc();
        chk("err1", 32'(div_err), 1);
        chk_wave("err1_w", 5, 0);
        div_in = 8'd0;
        cyc();
        chk("err0", 32'(div_err), 1);
        chk_wave("err0_w", 5, 1);
        div_load = 1'b0;
        cyc();
        chk("err_clear", 32'(div_err), 0);
        chk("err_active", 32'(div_active), 5);
        chk("err_busy", 32'(div_busy), 0);
        chk_wave("err_w", 5, 2);

        // Second load while busy is dropped silently.
        div_load = 1'b1;
        div_in   = 8'd6;
        cyc();
        chk("ld6_busy", 32'(div_busy), 1);
        chk_wave("ld6_c3", 5, 3);
        div_in = 8'd3;
        cyc();
        chk("ld3_busy", 32'(div_busy), 1);
        chk("ld3_noerr", 32'(div_err), 0);
        chk_wave("ld3_c4", 5, 4);
        div_load = 1'b0;
        cyc();
        chk("sw6_active", 32'(div_active), 6);
        chk("sw6_busy", 32'(div_busy), 0);
        chk_wave("sw6_c0", 6, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk_wave("n6", 6, i % 6);
        end

        // Park at cnt=1, then restart with a full period.
        cyc();
        chk_wave("park_c1", 6, 1);
        enable = 1'b0;
        cyc();
        chk("park_clk", 32'(clk_out), 0);
        chk("park_tick", 32'(tick), 0);
        cyc();
        chk("park2_clk", 32'(clk_out), 0);
        enable = 1'b1;
        cyc();
        chk_wave("reen_c0", 6, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk_wave("reen", 6, i % 6);
        end

        // Reset during SWITCH with 7 pending discards it.
        div_load = 1'b1;
        div_in   = 8'd7;
        cyc();
        div_load = 1'b0;
        chk("ld7_busy", 32'(div_busy), 1);
        cyc();
        reset_n = 1'b0;
        cyc();
        chk("rst7_active", 32'(div_active), 4);
        chk("rst7_busy", 32'(div_busy), 0);
        chk("rst7_clk", 32'(clk_out), 0);
        chk("rst7_tick", 32'(tick), 0);
        reset_n = 1'b1;
        cyc();
        chk_wave("post_rst_c0", 4, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk_wave("post_rst", 4, i % 4);
            chk("post_rst_active", 32'(div_active), 4);
        end

        // Parking during SWITCH keeps the pending divisor until re-enable.
        div_load = 1'b1;
        div_in   = 8'd3;
        cyc();
        div_load = 1'b0;
        enable   = 1'b0;
        chk("ld3b_busy", 32'(div_busy), 1);
        cyc();
        chk("sw_park_busy", 32'(div_busy), 1);
        chk("sw_park_clk", 32'(clk_out), 0);
        cyc();
        chk("sw_park_busy2", 32'(div_busy), 1);
        chk("sw_park_active", 32'(div_active), 4);
        enable = 1'b1;
        cyc();
        chk("sw_reen_active", 32'(div_active), 3);
        chk("sw_reen_busy", 32'(div_busy), 0);
        chk_wave("n3_c0", 3, 0);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk_wave("n3", 3, i % 3);
        end

        // Largest divisor, loaded while idle: 128 high, 127 low.
        enable = 1'b0;
        cyc();
        div_load = 1'b1;
        div_in   = 8'd255;
        cyc();
        div_load = 1'b0;
        chk("ld255_busy", 32'(div_busy), 1);
        chk("ld255_active", 32'(div_active), 255);
        cyc();
        chk("ld255_busy_off", 32'(div_busy), 0);
        enable = 1'b1;
        for (int i = 0; i < 510; i++) begin
            cyc();
            chk_wave("n255", 255, i % 255);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
